// File: rtl/nes_ctrl_pkg.sv
// rtl/nes_ctrl_pkg.sv - shared constants and HID keycode to button decode for the NES controller port
package nes_ctrl_pkg;

   localparam int NUM_BTN   = 8;
   localparam int BTN_A     = 0;
   localparam int BTN_B     = 1;
   localparam int BTN_SEL   = 2;
   localparam int BTN_START = 3;
   localparam int BTN_UP    = 4;
   localparam int BTN_DOWN  = 5;
   localparam int BTN_LEFT  = 6;
   localparam int BTN_RIGHT = 7;

   localparam logic [7:0] KEY_K     = 8'h0E;
   localparam logic [7:0] KEY_J     = 8'h0D;
   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;

   localparam logic [15:0] JOY1_ADDR    = 16'h4016;
   localparam logic [15:0] JOY2_ADDR    = 16'h4017;
   localparam logic [7:0]  JOY_OPEN_BUS = 8'h40;

   // One-hot button mask for a keycode; unmapped codes give zero.
   function automatic logic [NUM_BTN-1:0] key_to_mask(input logic [7:0] key);
      logic [NUM_BTN-1:0] m;
      m = '0;
      case (key)
         KEY_K:     m[BTN_A]     = 1'b1;
         KEY_J:     m[BTN_B]     = 1'b1;
         KEY_SPACE: m[BTN_SEL]   = 1'b1;
         KEY_ENTER: m[BTN_START] = 1'b1;
         KEY_W:     m[BTN_UP]    = 1'b1;
         KEY_S:     m[BTN_DOWN]  = 1'b1;
         KEY_A:     m[BTN_LEFT]  = 1'b1;
         KEY_D:     m[BTN_RIGHT] = 1'b1;
         default:   m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/nes_button_hold.sv
// rtl/nes_button_hold.sv - per-button hold counter that keeps a key pressed across keycode gaps
module nes_button_hold #(
   parameter int HOLD_CYCLES = 30000,
   parameter int HOLD_W      = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_en,
   input  logic i_match,
   output logic o_pressed
);

   logic [HOLD_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (i_match)
            r_cnt <= HOLD_W'(HOLD_CYCLES);
         else if (r_cnt != '0)
            r_cnt <= r_cnt - HOLD_W'(1);
      end
   end

   assign o_pressed = (r_cnt != '0);

endmodule

// File: rtl/nes_controller_port.sv
// rtl/nes_controller_port.sv - $4016/$4017 controller responder: held buttons, strobe and serial shift
module nes_controller_port
   import nes_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES = 30000,
   parameter int HOLD_W      = 16
) (
   input  logic        CPU_CLK,
   input  logic        RESET,
   input  logic        ENABLE,
   input  logic [7:0]  controller_keycode,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_in,
   input  logic        cpu_rw_n,
   input  logic        cpu_access,
   output logic [7:0]  data_out,
   output logic        data_out_en,
   output logic [7:0]  buttons_debug
);

   logic [NUM_BTN-1:0] w_key_mask;
   logic [NUM_BTN-1:0] w_buttons;
   logic               w_sel1;
   logic               w_sel2;
   logic               w_wr_joy1;
   logic               w_rd_joy1;
   logic               w_bit0;
   logic               w_unused_data;
   logic               r_strobe;
   logic [7:0]         r_shift;

   assign w_key_mask    = key_to_mask(controller_keycode);
   assign w_sel1        = (cpu_addr == JOY1_ADDR);
   assign w_sel2        = (cpu_addr == JOY2_ADDR);
   assign w_wr_joy1     = ENABLE & cpu_access & ~cpu_rw_n & w_sel1;
   assign w_rd_joy1     = ENABLE & cpu_access &  cpu_rw_n & w_sel1;
   assign w_unused_data = &{1'b0, cpu_data_in[7:1]};

   genvar g;
   generate
      for (g = 0; g < NUM_BTN; g++) begin : g_btn
         nes_button_hold #(
            .HOLD_CYCLES (HOLD_CYCLES),
            .HOLD_W      (HOLD_W)
         ) u_hold (
            .i_clk     (CPU_CLK),
            .i_rst     (RESET),
            .i_en      (ENABLE),
            .i_match   (w_key_mask[g]),
            .o_pressed (w_buttons[g])
         );
      end
   endgenerate

   always_ff @(posedge CPU_CLK) begin
      if (RESET)
         r_strobe <= 1'b0;
      else if (w_wr_joy1)
         r_strobe <= cpu_data_in[0];
   end

   // Reads refill from the top with 1s, so a drained register answers 1 forever.
   always_ff @(posedge CPU_CLK) begin
      if (RESET)
         r_shift <= 8'h00;
      else if (ENABLE) begin
         if (r_strobe)
            r_shift <= w_buttons;
         else if (w_rd_joy1)
            r_shift <= {1'b1, r_shift[7:1]};
      end
   end

   assign w_bit0 = r_strobe ? w_buttons[BTN_A] : r_shift[0];

   always_comb begin
      data_out = 8'h00;
      if (cpu_rw_n && w_sel1)
         data_out = JOY_OPEN_BUS | {7'b0, w_bit0};
      else if (cpu_rw_n && w_sel2)
         data_out = JOY_OPEN_BUS;
   end

   assign data_out_en   = cpu_rw_n & (w_sel1 | w_sel2);
   assign buttons_debug = w_buttons;

endmodule

// File: tb/tb_nes_controller_port.sv
// tb/tb_nes_controller_port.sv - randomized and directed bench against a read-index reference model
module tb_nes_controller_port;

   localparam int HOLD = 60;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [7:0]  kc;
   logic [15:0] addr;
   logic [7:0]  din;
   logic        rw_n;
   logic        acc;
   logic [7:0]  data_out;
   logic        data_out_en;
   logic [7:0]  dbg;

   int total = 0;
   int bad   = 0;

   // Reference model: hold time left per button, latched report byte and read index.
   int         m_hold [8];
   logic       m_strobe;
   logic [7:0] m_latched;
   int         m_reads;

   logic [7:0] obs_data;
   logic       obs_en;
   logic [7:0] obs_dbg;

   nes_controller_port #(.HOLD_CYCLES(HOLD), .HOLD_W(8)) dut (
      .CPU_CLK            (clk),
      .RESET              (rst),
      .ENABLE             (en),
      .controller_keycode (kc),
      .cpu_addr           (addr),
      .cpu_data_in        (din),
      .cpu_rw_n           (rw_n),
      .cpu_access         (acc),
      .data_out           (data_out),
      .data_out_en        (data_out_en),
      .buttons_debug      (dbg)
   );

   always #5 clk = ~clk;

   function automatic int key_idx(input logic [7:0] k);
      case (k)
         8'h0E: return 0;
         8'h0D: return 1;
         8'h2C: return 2;
         8'h28: return 3;
         8'h1A: return 4;
         8'h16: return 5;
         8'h04: return 6;
         8'h07: return 7;
         default: return -1;
      endcase
   endfunction

   function automatic logic [7:0] m_buttons();
      logic [7:0] b;
      for (int i = 0; i < 8; i++) b[i] = (m_hold[i] > 0);
      return b;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_hold[i] = 0;
      m_strobe  = 1'b0;
      m_latched = 8'h00;
      m_reads   = 0;
   endtask

   task automatic cyc(input logic c_en, input logic [7:0] c_kc, input logic c_acc,
                      input logic c_rw, input logic [15:0] c_addr, input logic [7:0] c_din,
                      input logic c_rst);
      logic       bit0;
      logic [7:0] exp_data;
      logic       exp_en;
      logic [7:0] btn;
      logic       nxt_strobe;
      int         k;
      en = c_en; kc = c_kc; acc = c_acc; rw_n = c_rw; addr = c_addr; din = c_din; rst = c_rst;
      #3;
      btn    = m_buttons();
      bit0   = m_strobe ? btn[0] : (m_reads < 8 ? m_latched[m_reads] : 1'b1);
      exp_en = c_rw && (c_addr == 16'h4016 || c_addr == 16'h4017);
      if (!exp_en)                  exp_data = 8'h00;
      else if (c_addr == 16'h4017)  exp_data = 8'h40;
      else                          exp_data = {7'b0100000, bit0};
      obs_data = data_out; obs_en = data_out_en; obs_dbg = dbg;
      chk("data_out", {8'h0, obs_data}, {8'h0, exp_data});
      chk("data_out_en", {15'h0, obs_en}, {15'h0, exp_en});
      chk("buttons_debug", {8'h0, obs_dbg}, {8'h0, btn});
      if (c_rst) begin
         model_reset();
      end else if (c_en) begin
         nxt_strobe = m_strobe;
         if (c_acc && !c_rw && c_addr == 16'h4016) nxt_strobe = c_din[0];
         if (m_strobe) begin
            m_latched = btn;
            m_reads   = 0;
         end else if (c_acc && c_rw && c_addr == 16'h4016 && m_reads < 8) begin
            m_reads++;
         end
         m_strobe = nxt_strobe;
         k = key_idx(c_kc);
         for (int i = 0; i < 8; i++) begin
            if (i == k)          m_hold[i] = HOLD;
            else if (m_hold[i] > 0) m_hold[i]--;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n, input logic [7:0] c_kc, input logic c_en);
      for (int i = 0; i < n; i++) cyc(c_en, c_kc, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
   endtask

   task automatic wr(input logic [7:0] c_kc, input logic [7:0] d);
      cyc(1'b1, c_kc, 1'b1, 1'b0, 16'h4016, d, 1'b0);
   endtask

   task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] c_kc,
                     input logic [7:0] exp);
      cyc(1'b1, c_kc, 1'b1, 1'b1, a, 8'h00, 1'b0);
      chk(tag, {8'h0, obs_data}, {8'h0, exp});
   endtask

   logic [7:0] exp_up [10];
   logic [7:0] codes  [10];

   initial begin
      exp_up = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
      codes  = '{8'h0E, 8'h0D, 8'h2C, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h00, 8'h55};
      rst = 1'b1; en = 1'b1; kc = 8'h00; addr = 16'h0000; din = 8'h00; rw_n = 1'b1; acc = 1'b0;
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      idle(1, 8'h00, 1'b1);
      chk("reset_dbg", {8'h0, obs_dbg}, 16'h0000);
      for (int i = 0; i < 8; i++) rd("reset_read", 16'h4016, 8'h00, 8'h40);

      idle(10, 8'h1A, 1'b1);
      wr(8'h1A, 8'h01);
      wr(8'h1A, 8'h00);
      for (int i = 0; i < 10; i++) rd("up_read", 16'h4016, 8'h1A, exp_up[i]);

      idle(HOLD + 2, 8'h00, 1'b1);
      idle(1, 8'h0E, 1'b1);
      idle(3, 8'h07, 1'b1);
      idle(1, 8'h00, 1'b1);
      chk("combo_dbg", {8'h0, dbg}, 16'h0081);
      wr(8'h00, 8'h01);
      wr(8'h00, 8'h00);
      for (int i = 0; i < 8; i++)
         rd("combo_read", 16'h4016, 8'h00, (i == 0 || i == 7) ? 8'h41 : 8'h40);
      idle(HOLD + 2, 8'h00, 1'b1);
      chk("combo_expire", {8'h0, obs_dbg}, 16'h0000);

      wr(8'h0E, 8'h01);
      idle(2, 8'h0E, 1'b1);
      for (int i = 0; i < 3; i++) rd("strobe_live", 16'h4016, 8'h0E, 8'h41);
      idle(HOLD + 2, 8'h00, 1'b1);
      rd("strobe_expired", 16'h4016, 8'h00, 8'h40);
      wr(8'h00, 8'h00);

      rd("joy2_read", 16'h4017, 8'h00, 8'h40);
      chk("joy2_en", {15'h0, obs_en}, 16'h0001);
      rd("other_read", 16'h2002, 8'h00, 8'h00);
      chk("other_en", {15'h0, obs_en}, 16'h0000);

      idle(1, 8'h1A, 1'b1);
      idle(1, 8'h0E, 1'b1);
      wr(8'h00, 8'h01);
      wr(8'h00, 8'h00);
      for (int i = 0; i < 3; i++) rd("pre_reset_read", 16'h4016, 8'h00, (i == 0) ? 8'h41 : 8'h40);
      cyc(1'b1, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b1);
      rd("post_reset_read", 16'h4016, 8'h00, 8'h40);
      chk("post_reset_dbg", {8'h0, obs_dbg}, 16'h0000);
      idle(5, 8'h28, 1'b0);
      idle(1, 8'h00, 1'b1);
      chk("disabled_dbg", {8'h0, obs_dbg}, 16'h0000);

      for (int n = 0; n < 3000; n++) begin
         logic [7:0]  r_kc;
         logic [15:0] r_addr;
         int          sel;
         r_kc = codes[$urandom_range(0, 9)];
         sel  = $urandom_range(0, 7);
         if (sel < 4)       r_addr = 16'h4016;
         else if (sel == 4) r_addr = 16'h4017;
         else if (sel == 5) r_addr = 16'h2002;
         else               r_addr = 16'($urandom);
         cyc($urandom_range(0, 9) != 0, r_kc, $urandom_range(0, 1) == 1,
             $urandom_range(0, 3) != 0, r_addr, 8'($urandom),
             $urandom_range(0, 499) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
